pipe_ctrl: RTL and testbench

Pipeline sequencer for the 5-stage MIPS core. Drives the per-stage hold (breakpoint-style freeze) and active-low clean (flush) inputs of the IF/ID, ID/EX, EX/MEM and MEM/WB registers, plus the PC hold.

---
 rtl/pipe_ctrl.sv | 150 +++++++++++++++
 tb/tb_pipe_ctrl.sv | 275 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/pipe_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : pipe_ctrl
// Purpose  : 5-stage MIPS pipeline sequencer: debug FSM, load-use stall,
//            taken-branch flush and advance-cycle counter.
// Revision : 1.0 - initial release
// ============================================================================
module pipe_ctrl #(
    parameter int START_HALTED = 0,
    parameter int CNT_W        = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             run_req,
    input  logic             halt_req,
    input  logic             step_req,
    input  logic             bp_en,
    input  logic [31:0]      bp_addr,
    input  logic [31:0]      if_pc,
    input  logic [4:0]       ifid_rs,
    input  logic [4:0]       ifid_rt,
    input  logic             idex_memtoreg,
    input  logic [4:0]       idex_writereg,
    input  logic             exmem_taken,
    input  logic             exmem_trap,
    output logic             pc_hold,
    output logic             ifid_hold,
    output logic             idex_hold,
    output logic             exmem_hold,
    output logic             memwb_hold,
    output logic             ifid_clean_n,
    output logic             idex_clean_n,
    output logic             exmem_clean_n,
    output logic             halted,
    output logic [1:0]       state,
    output logic [CNT_W-1:0] adv_cnt
);

    typedef enum logic [1:0] {
        ST_RUN  = 2'd0,
        ST_HALT = 2'd1,
        ST_STEP = 2'd2,
        ST_TRAP = 2'd3
    } state_t;

    localparam state_t c_RESET_STATE = (START_HALTED != 0) ? ST_HALT : ST_RUN;

    state_t           r_state;
    state_t           w_state_nxt;
    logic             r_bp_skip;
    logic             w_bp_skip_nxt;
    logic             r_trap_skip;
    logic [CNT_W-1:0] r_adv_cnt;

    logic w_bp_hit;
    logic w_adv;
    logic w_load_use;
    logic w_pc_hold;

    assign w_bp_hit = bp_en && (if_pc == bp_addr) && !r_bp_skip && (r_state == ST_RUN);
    assign w_adv    = ((r_state == ST_RUN) && !w_bp_hit) || (r_state == ST_STEP);

    assign w_load_use = idex_memtoreg && (idex_writereg != 5'd0) &&
                        ((idex_writereg == ifid_rs) || (idex_writereg == ifid_rt));

    // Stage controls; a taken branch outranks the load-use bubble
    always_comb begin
        w_pc_hold     = 1'b1;
        ifid_hold     = 1'b1;
        idex_hold     = 1'b1;
        exmem_hold    = 1'b1;
        memwb_hold    = 1'b1;
        ifid_clean_n  = 1'b1;
        idex_clean_n  = 1'b1;
        exmem_clean_n = 1'b1;
        if (rst_n && w_adv) begin
            w_pc_hold  = 1'b0;
            ifid_hold  = 1'b0;
            idex_hold  = 1'b0;
            exmem_hold = 1'b0;
            memwb_hold = 1'b0;
            if (exmem_taken) begin
                ifid_clean_n  = 1'b0;
                idex_clean_n  = 1'b0;
                exmem_clean_n = 1'b0;
            end else if (w_load_use) begin
                w_pc_hold    = 1'b1;
                ifid_hold    = 1'b1;
                idex_clean_n = 1'b0;
            end
        end
    end

    assign pc_hold = w_pc_hold;

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_RUN: begin
                if (exmem_trap && !r_trap_skip) w_state_nxt = ST_TRAP;
                else if (halt_req)              w_state_nxt = ST_HALT;
                else if (w_bp_hit)              w_state_nxt = ST_HALT;
            end
            ST_HALT: begin
                if (run_req)       w_state_nxt = ST_RUN;
                else if (step_req) w_state_nxt = ST_STEP;
            end
            ST_STEP: begin
                w_state_nxt = exmem_trap ? ST_TRAP : ST_HALT;
            end
            ST_TRAP: begin
                if (run_req) w_state_nxt = ST_RUN;
            end
            default: w_state_nxt = c_RESET_STATE;
        endcase
    end

    // Resume skips the breakpoint until the PC has really moved past it
    always_comb begin
        w_bp_skip_nxt = r_bp_skip;
        if (((r_state == ST_HALT) || (r_state == ST_TRAP)) && (w_state_nxt != r_state) &&
            (w_state_nxt != ST_TRAP)) begin
            w_bp_skip_nxt = 1'b1;
        end else if ((r_state == ST_RUN) && w_adv && !w_pc_hold) begin
            w_bp_skip_nxt = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= c_RESET_STATE;
            r_bp_skip   <= 1'b0;
            r_trap_skip <= 1'b0;
            r_adv_cnt   <= '0;
        end else begin
            r_state     <= w_state_nxt;
            r_bp_skip   <= w_bp_skip_nxt;
            r_trap_skip <= (r_state == ST_TRAP) && (w_state_nxt == ST_RUN);
            if (w_adv) begin
                r_adv_cnt <= r_adv_cnt + CNT_W'(1);
            end
        end
    end

    assign state   = r_state;
    assign halted  = (r_state == ST_HALT) || (r_state == ST_TRAP);
    assign adv_cnt = r_adv_cnt;

endmodule
`default_nettype wire

// File: tb/tb_pipe_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_pipe_ctrl
// Purpose  : Directed self-checking bench for pipe_ctrl with expectation queue.
// Revision : 1.0 - initial release
// ============================================================================
module tb_pipe_ctrl;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        run_req, halt_req, step_req, bp_en;
    logic [31:0] bp_addr, if_pc;
    logic [4:0]  ifid_rs, ifid_rt, idex_writereg;
    logic        idex_memtoreg, exmem_taken, exmem_trap;

    logic        pc_hold, ifid_hold, idex_hold, exmem_hold, memwb_hold;
    logic        ifid_clean_n, idex_clean_n, exmem_clean_n, halted;
    logic [1:0]  state;
    logic [31:0] adv_cnt;

    logic        d2_pc_hold, d2_ifid_hold, d2_idex_hold, d2_exmem_hold, d2_memwb_hold;
    logic        d2_ifid_clean_n, d2_idex_clean_n, d2_exmem_clean_n, d2_halted;
    logic [1:0]  d2_state;
    logic [2:0]  d2_adv_cnt;

    pipe_ctrl #(.START_HALTED(0), .CNT_W(32)) u_dut (
        .clk(clk), .rst_n(rst_n), .run_req(run_req), .halt_req(halt_req),
        .step_req(step_req), .bp_en(bp_en), .bp_addr(bp_addr), .if_pc(if_pc),
        .ifid_rs(ifid_rs), .ifid_rt(ifid_rt), .idex_memtoreg(idex_memtoreg),
        .idex_writereg(idex_writereg), .exmem_taken(exmem_taken), .exmem_trap(exmem_trap),
        .pc_hold(pc_hold), .ifid_hold(ifid_hold), .idex_hold(idex_hold),
        .exmem_hold(exmem_hold), .memwb_hold(memwb_hold), .ifid_clean_n(ifid_clean_n),
        .idex_clean_n(idex_clean_n), .exmem_clean_n(exmem_clean_n), .halted(halted),
        .state(state), .adv_cnt(adv_cnt)
    );

    pipe_ctrl #(.START_HALTED(1), .CNT_W(3)) u_dut2 (
        .clk(clk), .rst_n(rst_n), .run_req(run_req), .halt_req(halt_req),
        .step_req(step_req), .bp_en(bp_en), .bp_addr(bp_addr), .if_pc(if_pc),
        .ifid_rs(ifid_rs), .ifid_rt(ifid_rt), .idex_memtoreg(idex_memtoreg),
        .idex_writereg(idex_writereg), .exmem_taken(exmem_taken), .exmem_trap(exmem_trap),
        .pc_hold(d2_pc_hold), .ifid_hold(d2_ifid_hold), .idex_hold(d2_idex_hold),
        .exmem_hold(d2_exmem_hold), .memwb_hold(d2_memwb_hold),
        .ifid_clean_n(d2_ifid_clean_n), .idex_clean_n(d2_idex_clean_n),
        .exmem_clean_n(d2_exmem_clean_n), .halted(d2_halted),
        .state(d2_state), .adv_cnt(d2_adv_cnt)
    );

    always #5 clk = ~clk;

    // Control vector: {pc, ifid, idex, exmem, memwb holds, ifid, idex, exmem clean_n}
    localparam logic [7:0] c_FRZ = 8'hFF;
    localparam logic [7:0] c_RUN = 8'h07;
    localparam logic [7:0] c_LU  = 8'hC5;
    localparam logic [7:0] c_TK  = 8'h00;

    localparam int c_SEL_CTL = 0, c_SEL_ST = 1, c_SEL_HLT = 2, c_SEL_CNT = 3;
    localparam int c_SEL_D2ST = 4, c_SEL_D2CNT = 5, c_SEL_D2CTL = 6, c_SEL_D2HLT = 7;

    typedef struct {
        string       tag;
        int          sel;
        logic [31:0] exp;
    } exp_t;

    exp_t        sb_q[$];
    int          n_checks = 0;
    int          n_pass   = 0;
    logic [31:0] exp_cnt  = 0;

    function automatic logic [31:0] observe(input int sel);
        case (sel)
            c_SEL_CTL:   return {24'd0, pc_hold, ifid_hold, idex_hold, exmem_hold, memwb_hold,
                                 ifid_clean_n, idex_clean_n, exmem_clean_n};
            c_SEL_ST:    return {30'd0, state};
            c_SEL_HLT:   return {31'd0, halted};
            c_SEL_CNT:   return adv_cnt;
            c_SEL_D2ST:  return {30'd0, d2_state};
            c_SEL_D2CNT: return {29'd0, d2_adv_cnt};
            c_SEL_D2CTL: return {24'd0, d2_pc_hold, d2_ifid_hold, d2_idex_hold, d2_exmem_hold,
                                 d2_memwb_hold, d2_ifid_clean_n, d2_idex_clean_n,
                                 d2_exmem_clean_n};
            default:     return {31'd0, d2_halted};
        endcase
    endfunction

    task automatic expect_v(input string tag, input int sel, input logic [31:0] exp);
        exp_t it;
        it.tag = tag;
        it.sel = sel;
        it.exp = exp;
        sb_q.push_back(it);
    endtask

    task automatic check_now();
        exp_t        it;
        logic [31:0] obs;
        while (sb_q.size() > 0) begin
            it  = sb_q.pop_front();
            obs = observe(it.sel);
            n_checks = n_checks + 1;
            assert (obs === it.exp) n_pass = n_pass + 1;
            else $error("FAIL %s: observed 0x%0h expected 0x%0h", it.tag, obs, it.exp);
        end
    endtask

    // Compare at the falling edge, then move to just after the next rising edge
    task automatic tick(input bit adv);
        @(negedge clk);
        check_now();
        @(posedge clk);
        #1;
        if (adv) exp_cnt = exp_cnt + 1;
    endtask

    initial begin
        rst_n = 1'b0; run_req = 0; halt_req = 0; step_req = 0; bp_en = 0;
        bp_addr = 32'h0; if_pc = 32'h0; ifid_rs = 0; ifid_rt = 0;
        idex_memtoreg = 0; idex_writereg = 0; exmem_taken = 0; exmem_trap = 0;

        // Reset values of both configurations
        expect_v("rst_ctl", c_SEL_CTL, c_FRZ);
        expect_v("rst_state", c_SEL_ST, 0);
        expect_v("rst_cnt", c_SEL_CNT, 0);
        expect_v("d2_rst_state", c_SEL_D2ST, 1);
        expect_v("d2_rst_ctl", c_SEL_D2CTL, c_FRZ);
        expect_v("d2_rst_halted", c_SEL_D2HLT, 1);
        tick(0);
        rst_n = 1'b1;

        // Halted-start instance released by run_req, 3-bit counter wraps
        run_req = 1;
        expect_v("run_ctl", c_SEL_CTL, c_RUN);
        expect_v("d2_halt_ctl", c_SEL_D2CTL, c_FRZ);
        tick(1);
        run_req = 0;
        expect_v("d2_run_state", c_SEL_D2ST, 0);
        for (int i = 0; i < 9; i++) tick(1);
        expect_v("d2_cnt_wrap", c_SEL_D2CNT, 1);
        expect_v("cnt_10", c_SEL_CNT, 10);
        check_now();

        // Mid-run reset
        rst_n = 1'b0;
        #1;
        expect_v("rst2_cnt", c_SEL_CNT, 0);
        expect_v("rst2_ctl", c_SEL_CTL, c_FRZ);
        tick(0);
        rst_n = 1'b1;
        exp_cnt = 0;

        // Load-use stalls
        idex_memtoreg = 1; idex_writereg = 8; ifid_rt = 8;
        expect_v("lu_rt", c_SEL_CTL, c_LU);
        tick(1);
        idex_writereg = 0; ifid_rt = 0;
        expect_v("lu_r0", c_SEL_CTL, c_RUN);
        tick(1);
        idex_writereg = 5; ifid_rs = 5; ifid_rt = 8;
        expect_v("lu_rs", c_SEL_CTL, c_LU);
        tick(1);
        idex_memtoreg = 0;
        expect_v("lu_noload", c_SEL_CTL, c_RUN);
        tick(1);

        // Taken branch overrides load-use
        idex_memtoreg = 1; idex_writereg = 8; ifid_rt = 8; exmem_taken = 1;
        expect_v("taken_lu", c_SEL_CTL, c_TK);
        tick(1);
        idex_memtoreg = 0; exmem_taken = 0; ifid_rs = 0; ifid_rt = 0; idex_writereg = 0;
        expect_v("cnt_after_hazards", c_SEL_CNT, exp_cnt);

        // Breakpoint
        bp_en = 1; bp_addr = 32'h40; if_pc = 32'h3C;
        expect_v("bp_pre", c_SEL_CTL, c_RUN);
        tick(1);
        if_pc = 32'h40;
        expect_v("bp_hit_ctl", c_SEL_CTL, c_FRZ);
        expect_v("bp_hit_state", c_SEL_ST, 0);
        tick(0);
        expect_v("bp_halt_state", c_SEL_ST, 1);
        expect_v("bp_halted", c_SEL_HLT, 1);
        expect_v("bp_halt_ctl", c_SEL_CTL, c_FRZ);
        tick(0);
        expect_v("bp_cnt_frozen", c_SEL_CNT, exp_cnt);
        run_req = 1;
        tick(0);
        run_req = 0;
        idex_memtoreg = 1; idex_writereg = 9; ifid_rs = 9;
        expect_v("bp_resume_lu", c_SEL_CTL, c_LU);
        expect_v("bp_resume_state", c_SEL_ST, 0);
        tick(1);
        idex_memtoreg = 0;
        expect_v("bp_resume_go", c_SEL_CTL, c_RUN);
        tick(1);
        if_pc = 32'h44;
        expect_v("bp_left_ctl", c_SEL_CTL, c_RUN);
        expect_v("bp_left_state", c_SEL_ST, 0);
        tick(1);
        bp_en = 0;

        // Halt and single steps
        halt_req = 1;
        expect_v("halt_req_cycle", c_SEL_CTL, c_RUN);
        tick(1);
        halt_req = 0;
        expect_v("halt_state", c_SEL_ST, 1);
        tick(0);
        for (int k = 0; k < 3; k++) begin
            step_req = 1;
            expect_v("step_req_state", c_SEL_ST, 1);
            expect_v("step_req_ctl", c_SEL_CTL, c_FRZ);
            tick(0);
            step_req = 0;
            expect_v("step_state", c_SEL_ST, 2);
            expect_v("step_ctl", c_SEL_CTL, c_RUN);
            tick(1);
            expect_v("step_back", c_SEL_ST, 1);
            tick(0);
            tick(0);
        end
        expect_v("step_cnt", c_SEL_CNT, exp_cnt);
        run_req = 1; step_req = 1;
        tick(0);
        run_req = 0; step_req = 0;
        expect_v("run_wins", c_SEL_ST, 0);
        tick(1);

        // Trap
        exmem_trap = 1;
        expect_v("trap_cycle", c_SEL_CTL, c_RUN);
        tick(1);
        exmem_trap = 0;
        expect_v("trap_state", c_SEL_ST, 3);
        expect_v("trap_halted", c_SEL_HLT, 1);
        step_req = 1; halt_req = 1;
        tick(0);
        step_req = 0; halt_req = 0;
        expect_v("trap_ignore", c_SEL_ST, 3);
        expect_v("trap_ctl", c_SEL_CTL, c_FRZ);
        run_req = 1;
        tick(0);
        run_req = 0; exmem_trap = 1;
        expect_v("trap_drain_state", c_SEL_ST, 0);
        expect_v("trap_drain_ctl", c_SEL_CTL, c_RUN);
        tick(1);
        exmem_trap = 0;
        expect_v("trap_drained", c_SEL_ST, 0);
        expect_v("trap_cnt", c_SEL_CNT, exp_cnt);
        halt_req = 1;
        tick(1);
        halt_req = 0;
        step_req = 1;
        tick(0);
        step_req = 0;

        // Asynchronous reset while in STEP
        expect_v("pre_rst_step", c_SEL_ST, 2);
        check_now();
        #2;
        rst_n = 1'b0;
        #1;
        expect_v("async_rst_state", c_SEL_ST, 0);
        expect_v("async_rst_cnt", c_SEL_CNT, 0);
        expect_v("async_rst_ctl", c_SEL_CTL, c_FRZ);
        check_now();
        tick(0);
        rst_n = 1'b1;

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
